// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI target
package spi_target_pkg;

    // Byte framing state: IDLE while bit_cnt is 0, SHIFT while a byte is in progress
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Byte shifted out to the host when nothing has been buffered
    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - two-flop synchronizer for one asynchronous input
module spi_target_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives a settled copy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - mode-0 SPI target with RX stream, one-entry TX buffer and idle timeout
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         IdleTimeout = 256,
    parameter logic [7:0] FillByte    = FILL_BYTE_DEFAULT
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_i,
    input  logic       spi_sck_i,
    input  logic       spi_sdi_i,
    output logic       spi_sdo_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       rx_overflow_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int              CntW     = $clog2(IdleTimeout + 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IdleTimeout - 1);
    localparam logic [CntW-1:0] IdleMax  = CntW'(IdleTimeout);

    logic w_sck_s;
    logic w_sdi_s;

    logic            r_sck_d;
    logic            r_sdi_d;
    logic            r_rise;
    logic            r_fall;
    logic [CntW-1:0] r_idle_cnt;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_ovf;
    logic       r_frame_err;
    logic [7:0] r_tx_shift;
    logic [7:0] r_tx_buf;
    logic       r_tx_empty;
    logic       r_fresh;

    logic       w_timeout;
    logic       w_last_bit;
    logic [7:0] w_rx_byte;

    spi_target_sync u_sync_sck (
        .i_clk (clk_sys_i),
        .i_rst (rst_sys_i),
        .i_d   (spi_sck_i),
        .o_q   (w_sck_s)
    );

    spi_target_sync u_sync_sdi (
        .i_clk (clk_sys_i),
        .i_rst (rst_sys_i),
        .i_d   (spi_sdi_i),
        .o_q   (w_sdi_s)
    );

    // Registered SCK edge strobes; SDI is delayed one more flop so it lines up with the strobe
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_sck_d <= 1'b0;
            r_sdi_d <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sck_d <= w_sck_s;
            r_sdi_d <= w_sdi_s;
            r_rise  <= w_sck_s & ~r_sck_d;
            r_fall  <= ~w_sck_s & r_sck_d;
        end
    end

    // Cycles since the last SCK edge, saturating at the timeout value
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_idle_cnt <= '0;
        end else if (r_rise || r_fall) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IdleMax) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // A strobe in the same cycle always wins over the timeout
    assign w_timeout  = ~r_rise & ~r_fall & (r_idle_cnt == IdleLast);
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_rx_byte  = {r_rx_shift[6:0], r_sdi_d};

    // Byte framing FSM with RX capture, TX shifting and TX buffer management
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'd0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_shift  <= FillByte;
            r_tx_buf    <= 8'd0;
            r_tx_empty  <= 1'b1;
            r_fresh     <= 1'b1;
        end else begin
            r_rx_ovf    <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end

            // Buffer only loads while empty, so it never collides with a take below
            if (tx_valid_i && r_tx_empty) begin
                r_tx_buf   <= tx_data_i;
                r_tx_empty <= 1'b0;
            end

            if (r_rise) begin
                r_rx_shift <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (w_last_bit) begin
                    r_state    <= ST_IDLE;
                    r_rx_data  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                    r_rx_ovf   <= r_rx_valid & ~rx_ready_i;
                    if (!r_tx_empty) begin
                        r_tx_shift <= r_tx_buf;
                        r_tx_empty <= 1'b1;
                        r_fresh    <= 1'b0;
                    end else begin
                        r_tx_shift <= FillByte;
                        r_fresh    <= 1'b1;
                    end
                end else begin
                    r_state <= ST_SHIFT;
                    r_fresh <= 1'b0;
                end
            end else if (r_fall && r_state == ST_SHIFT) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end else if (w_timeout && r_state == ST_SHIFT) begin
                // Abort the partial byte; the TX side restarts as if the byte had ended
                r_state     <= ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_rx_shift  <= 8'd0;
                r_frame_err <= 1'b1;
                if (!r_tx_empty) begin
                    r_tx_shift <= r_tx_buf;
                    r_tx_empty <= 1'b1;
                    r_fresh    <= 1'b0;
                end else begin
                    r_tx_shift <= FillByte;
                    r_fresh    <= 1'b1;
                end
            end else if (r_state == ST_IDLE && r_fresh && !r_tx_empty) begin
                // Idle preload so the first bit is on SDO before the host's first rise
                r_tx_shift <= r_tx_buf;
                r_tx_empty <= 1'b1;
                r_fresh    <= 1'b0;
            end
        end
    end

    assign spi_sdo_o     = r_tx_shift[7];
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_ready_o    = r_tx_empty;
    assign rx_overflow_o = r_rx_ovf;
    assign frame_err_o   = r_frame_err;
    assign busy_o        = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - scoreboard bench for spi_target with a host-level reference model
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       sdi;
    logic       sdo;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_ovf;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int ovf_seen = 0;
    int ferr_seen = 0;
    bit hold_low = 1'b0;
    bit rand_ready_en = 1'b0;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];

    spi_target dut (
        .clk_sys_i     (clk),
        .rst_sys_i     (rst),
        .spi_sck_i     (sck),
        .spi_sdi_i     (sdi),
        .spi_sdo_o     (sdo),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_overflow_o (rx_ovf),
        .frame_err_o   (frame_err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: counts pulses and pops the scoreboard on every RX handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ovf) ovf_seen++;
            if (frame_err) ferr_seen++;
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_rx.pop_front());
                end
            end
        end
    end

    // Consumer ready: held low on request, otherwise 1 or short random stalls
    initial begin
        int low;
        low = 0;
        rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) begin
                rx_ready = 1'b0;
            end else if (rand_ready_en && low < 6 && $urandom_range(0, 3) == 0) begin
                rx_ready = 1'b0;
                low++;
            end else begin
                rx_ready = 1'b1;
                low = 0;
            end
        end
    end

    // Host side of one byte (or its first nbits), SCK high/low 4 cycles each
    task automatic host_byte(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sdi = mosi[i];
            cyc(4);
            miso[i] = sdo;
            sck = 1'b1;
            cyc(4);
            sck = 1'b0;
        end
    endtask

    // Model: a host byte carries the oldest accepted TX byte, else 8'hFF
    task automatic do_byte(input logic [7:0] mosi);
        logic [7:0] exp_miso;
        logic [7:0] miso;
        exp_miso = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
        exp_rx.push_back(mosi);
        host_byte(mosi, 8, miso);
        check("miso", miso, exp_miso);
        cyc(2);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            cyc(1);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_wait: got 0 expected 1");
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            cyc(1);
            tx_valid = 1'b0;
            tx_q.push_back(d);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_rx.size() != 0 && n < 500) begin
            cyc(1);
            n++;
        end
        check("rx_drain", exp_rx.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_sdo", sdo, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_overflow", rx_ovf, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] miso;
        int         n;
        int         ferr_base;

        rst = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'd0;
        cyc(5);
        check_reset_outputs();
        rst = 1'b0;
        cyc(3);

        // Loopback byte
        tx_write(8'hA5);
        cyc(3);
        check("tx_ready_pre", tx_ready, 1'b1);
        fork
            do_byte(8'h3C);
            begin
                cyc(20);
                check("busy_mid", busy, 1'b1);
            end
        join
        cyc(6);
        check("busy_after", busy, 1'b0);

        // Empty TX
        do_byte(8'h96);
        do_byte(8'h5A);

        // Back-to-back
        tx_write(8'h01);
        fork
            do_byte(8'h81);
            begin
                cyc(16);
                tx_write(8'h02);
            end
        join
        do_byte(8'h42);
        drain();

        // Overflow: second byte replaces the unaccepted first
        hold_low = 1'b1;
        cyc(2);
        do_byte(8'h11);
        do_byte(8'h22);
        cyc(4);
        exp_rx.delete();
        exp_rx.push_back(8'h22);
        check("ovf_valid", rx_valid, 1'b1);
        check("ovf_data", rx_data, 8'h22);
        check("ovf_count", ovf_seen, 1);
        hold_low = 1'b0;
        drain();

        // Timeout: partial TX byte is lost, buffered byte goes out next
        ferr_base = ferr_seen;
        tx_write(8'hE7);
        cyc(3);
        void'(tx_q.pop_front());
        fork
            host_byte(8'hC0, 5, miso);
            begin
                cyc(20);
                tx_write(8'h3D);
            end
        join
        cyc(250);
        check("busy_pre_timeout", busy, 1'b1);
        n = 0;
        while (ferr_seen == ferr_base && n < 100) begin
            cyc(1);
            n++;
        end
        cyc(2);
        check("frame_err_count", ferr_seen - ferr_base, 1);
        check("busy_post_timeout", busy, 1'b0);
        do_byte(8'h77);
        drain();

        // Reset mid-byte, with a byte preloaded and another buffered
        tx_write(8'h5E);
        tx_write(8'h6F);
        cyc(2);
        check("tx_full_pre_reset", tx_ready, 1'b0);
        host_byte(8'hF0, 3, miso);
        rst = 1'b1;
        cyc(2);
        check_reset_outputs();
        tx_q.delete();
        exp_rx.delete();
        rst = 1'b0;
        cyc(3);
        do_byte(8'hB4);
        drain();

        // Randomized traffic with random consumer stalls
        rand_ready_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1 && tx_ready) begin
                tx_write(8'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                fork
                    do_byte(b);
                    begin
                        cyc(12 + $urandom_range(0, 30));
                        if (tx_ready) tx_write(8'($urandom));
                    end
                join
            end else begin
                do_byte(b);
            end
            cyc($urandom_range(0, 8));
        end
        rand_ready_en = 1'b0;
        cyc(4);
        drain();
        check("ovf_total", ovf_seen, 1);
        check("ferr_total", ferr_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (responder) clocked by the system clock. It terminates the demo system's 3-wire SPI host (SCK, host-TX, host-RX; no chip select) so the host path can be exercised on the FPGA without external hardware. The block:

- oversamples SCK and host data on `clk_sys_i`;
- delivers each received byte on a valid/ready stream;
- shifts out a byte taken from a one-entry TX buffer.

It sits in the FPGA top beside the demo system, wired to the SPI pins or looped internally. Mode 0 (CPOL=0, CPHA=0), MSB first.

## Interface
Parameters:
- `IdleTimeout`, default 256: `clk_sys_i` cycles with no SCK edge after which a partial byte is aborted. Must be ≥ 16.
- `FillByte`, default 8'hFF: byte shifted out when no TX data is buffered.

Ports:
- `clk_sys_i`  in  1  system clock. Single clock domain.
- `rst_sys_i`  in  1  reset; asynchronous, active-high.
- `spi_sck_i`  in  1  SCK from the host; asynchronous to `clk_sys_i`.
- `spi_sdi_i`  in  1  host-to-target data; asynchronous.
- `spi_sdo_o`  out  1  target-to-host data.
- `rx_data_o`  out  8  received byte.
- `rx_valid_o`  out  1  `rx_data_o` is valid.
- `rx_ready_i`  in  1  consumer accepts the received byte.
- `tx_data_i`  in  8  byte to send.
- `tx_valid_i`  in  1  `tx_data_i` is valid.
- `tx_ready_o`  out  1  TX buffer is empty.
- `rx_overflow_o`  out  1  one-cycle pulse: an unaccepted RX byte was overwritten.
- `frame_err_o`  out  1  one-cycle pulse: partial byte aborted by the idle timeout.
- `busy_o`  out  1  a byte is in progress (`bit_cnt` ≠ 0).

## Operation
**Input conditioning**
- `spi_sck_i` and `spi_sdi_i` each pass through a 2-FF synchronizer.
- One further register on synchronized SCK gives single-cycle rise and fall strobes.

**Receive (rise strobe)**
- Shift synchronized SDI into `rx_shift` (LSB in) and increment the 3-bit `bit_cnt`.
- When `bit_cnt` wraps 7→0: `rx_data_o` ← completed byte and `rx_valid_o` ← 1.
- If `rx_valid_o` was already 1 and `rx_ready_i` is 0 in that same cycle: the new byte overwrites and `rx_overflow_o` pulses.
- Completion in the same cycle as acceptance: keep valid=1 with the new data, no overflow.

**Transmit**
- TX buffer: `tx_ready_o` = buffer empty; it loads on `tx_valid_i && tx_ready_o`.
- Shift register `tx_shift` drives `spi_sdo_o` = `tx_shift[7]`.
- Flag `fresh` = 1 while `tx_shift` holds `FillByte` and no bit of the current byte has been clocked.
- **Idle preload.** While `bit_cnt`=0 and `fresh`=1 and the buffer is full: move buffer → `tx_shift` and clear `fresh`.
- **Fall strobe** with `bit_cnt` ≠ 0: shift `tx_shift` left by one.
- **Byte end.** On the rise strobe that wraps `bit_cnt` 7→0, reload `tx_shift`:
  - from the buffer if full (buffer empties, `fresh`=0);
  - else from `FillByte` (`fresh`=1).
- The first rise strobe of a byte clears `fresh`.
- Data must be buffered before the first SCK rise of a byte; otherwise `FillByte` is sent for that byte.

**Idle timeout**
- `idle_cnt` resets on every rise or fall strobe and otherwise counts, saturating.
- On reaching `IdleTimeout` with `bit_cnt` ≠ 0:
  - `bit_cnt` ← 0 and the partial RX is discarded;
  - `frame_err_o` pulses;
  - `tx_shift` reloads per the byte-end rule; the partially sent TX byte is lost.
- With `bit_cnt`=0 the timeout has no effect.

**FSM**
- IDLE (`bit_cnt`=0) → SHIFT on a rise strobe.
- SHIFT → IDLE on the 8th rise or on timeout.
- Simultaneous rise strobe and timeout: the strobe wins and the counter resets.

**Reset values**
- `spi_sdo_o` = `FillByte[7]`.
- `rx_data_o` = 0, `rx_valid_o` = 0.
- `tx_ready_o` = 1.
- `rx_overflow_o` = 0, `frame_err_o` = 0, `busy_o` = 0.
- `fresh` = 1 and all counters 0.
- Reset mid-byte discards everything, including a buffered TX byte.

## Timing
- SCK high and low phases must each be ≥ 4 `clk_sys_i` cycles.
- Pin edge → strobe: 3 cycles.
- `rx_valid_o` rises 4 cycles after the 8th SCK rising edge at the pin.
- `spi_sdo_o` updates 4 cycles after an SCK falling edge at the pin, which is within the low phase.
- `tx_ready_o` returns high 1 cycle after the buffer → shift move.
- All outputs are registered.

## Structure
- Package `spi_target_pkg`: the state enum (IDLE, SHIFT) and the default `FillByte` constant.
- Sub-module `spi_target_sync`: 2-FF synchronizer, instanced once for SCK and once for SDI.

## Test plan
- **Loopback byte.** Buffer 8'hA5, then host clocks 8'h3C at SCK = clk/8 → `rx_data_o`=8'h3C with valid; sampled `spi_sdo_o` bits = 8'hA5 MSB first; `tx_ready_o` high before the first SCK.
- **Empty TX.** Host clocks two bytes with nothing buffered → host receives 8'hFF, 8'hFF.
- **Back-to-back.** Buffer 8'h01; buffer 8'h02 during byte 1 → host receives 8'h01 then 8'h02 with no gap byte.
- **Overflow.** Hold `rx_ready_i`=0 across two bytes 8'h11, 8'h22 → `rx_overflow_o` pulses once; `rx_data_o`=8'h22.
- **Timeout.** Stop after 5 bits, wait 256 cycles → `frame_err_o` pulses and `busy_o` drops; the next full byte 8'h77 is received correctly.
- **Reset mid-byte.** Assert `rst_sys_i` after 3 bits → all outputs at reset values; a subsequent byte is received intact.
